// File: rtl/c16_bank_pkg.sv
`default_nettype none
// c16_bank_pkg: shared types and constants for the 16-word write bank.
// Rev 1.0
package c16_bank_pkg;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  // Word index helpers
  localparam int FIRST_WORD = 0;
  localparam int LAST_WORD  = DEPTH - 1;

  typedef logic [0:0] state_t;
  localparam state_t IDLE  = 1'b0;
  localparam state_t CLEAR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/decode_4to16.sv
`default_nettype none
// decode_4to16: one-hot address decoder; all outputs low when en is low.
// Rev 1.0
module decode_4to16
  import c16_bank_pkg::*;
#(
  parameter int ADDR_W = c16_bank_pkg::ADDR_W,
  parameter int DEPTH  = c16_bank_pkg::DEPTH
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DEPTH-1:0]  sel
);

  always_comb begin
    sel = '0;
    if (en) sel = DEPTH'(1) << addr;
  end

endmodule
`default_nettype wire

// File: rtl/c16_word_write_bank.sv
`default_nettype none
// c16_word_write_bank: 16x16 word bank with valid/ready writes, sequenced clear
// and per-word written mask. Rev 1.0
module c16_word_write_bank
  import c16_bank_pkg::*;
#(
  parameter int WIDTH  = c16_bank_pkg::WIDTH,
  parameter int DEPTH  = c16_bank_pkg::DEPTH,
  parameter int ADDR_W = c16_bank_pkg::ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   clr_req,
  output logic                   clr_busy,
  output logic                   clr_done,
  output logic [DEPTH*WIDTH-1:0] word_bus,
  output logic [DEPTH-1:0]       valid_mask
);

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  state_t             state;
  logic [ADDR_W-1:0]  cnt;
  logic [WIDTH-1:0]   words [DEPTH];
  logic [DEPTH-1:0]   wr_sel;
  logic [DEPTH-1:0]   clr_sel;
  logic               wr_fire;

  assign wr_ready = (state == IDLE);
  assign clr_busy = (state == CLEAR);
  assign wr_fire  = wr_valid & wr_ready;

  decode_4to16 #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_wr_dec (
    .en   (wr_fire),
    .addr (wr_addr),
    .sel  (wr_sel)
  );

  decode_4to16 #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_clr_dec (
    .en   (clr_busy),
    .addr (cnt),
    .sel  (clr_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          // Counter wraps to 0 on the same edge that leaves CLEAR.
          cnt <= cnt + ADDR_W'(1);
          if (cnt == CNT_LAST) begin
            state    <= IDLE;
            clr_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write and clear selects are never active together: writes need IDLE, clears need CLEAR.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
      always_ff @(posedge clk) begin
        if (rst)             words[i] <= '0;
        else if (clr_sel[i]) words[i] <= '0;
        else if (wr_sel[i])  words[i] <= wr_data;
      end
      assign word_bus[i*WIDTH +: WIDTH] = words[i];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) valid_mask <= '0;
    else     valid_mask <= (valid_mask & ~clr_sel) | wr_sel;
  end

endmodule
`default_nettype wire

// File: tb/tb_c16_word_write_bank.sv
`default_nettype none
// tb_c16_word_write_bank: scoreboard bench; a reference model pushes the expected
// bank state each cycle and the monitor pops it after the clock edge.
module tb_c16_word_write_bank;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           wr_valid = 1'b0;
  logic           wr_ready;
  logic [3:0]     wr_addr = '0;
  logic [15:0]    wr_data = '0;
  logic           clr_req = 1'b0;
  logic           clr_busy;
  logic           clr_done;
  logic [255:0]   word_bus;
  logic [15:0]    valid_mask;

  c16_word_write_bank dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .word_bus   (word_bus),
    .valid_mask (valid_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [255:0] bus;
    logic [15:0]  mask;
    logic         ready;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] m_words [16];
  logic [15:0] m_mask  = '0;
  logic        m_busy  = 1'b0;
  logic [3:0]  m_cnt   = '0;
  logic        m_done  = 1'b0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [255:0] m_flat();
    logic [255:0] f;
    for (int i = 0; i < 16; i++) f[i*16 +: 16] = m_words[i];
    return f;
  endfunction

  // Advance the model by one edge using the current inputs, then let the DUT take the edge.
  task automatic step(input string tag);
    exp_t e;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_words[i] = '0;
      m_mask = '0; m_busy = 1'b0; m_cnt = '0; m_done = 1'b0;
    end else if (!m_busy) begin
      m_done = 1'b0;
      if (wr_valid) begin
        m_words[wr_addr] = wr_data;
        m_mask[wr_addr]  = 1'b1;
      end
      if (clr_req) begin
        m_busy = 1'b1;
        m_cnt  = '0;
      end
    end else begin
      m_words[m_cnt] = '0;
      m_mask[m_cnt]  = 1'b0;
      m_done = (m_cnt == 4'd15);
      if (m_cnt == 4'd15) m_busy = 1'b0;
      m_cnt = m_cnt + 4'd1;
    end
    e.tag = tag; e.bus = m_flat(); e.mask = m_mask;
    e.ready = !m_busy; e.busy = m_busy; e.done = m_done;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".bus"},   word_bus,   e.bus);
    check({e.tag, ".mask"},  {240'b0, valid_mask}, {240'b0, e.mask});
    check({e.tag, ".ready"}, {255'b0, wr_ready},   {255'b0, e.ready});
    check({e.tag, ".busy"},  {255'b0, clr_busy},   {255'b0, e.busy});
    check({e.tag, ".done"},  {255'b0, clr_done},   {255'b0, e.done});
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0; clr_req = 1'b0;
  endtask

  task automatic write(input logic [3:0] a, input logic [15:0] d, input string tag);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; clr_req = 1'b0;
    step(tag);
    wr_valid = 1'b0;
  endtask

  task automatic fill_all(input string tag);
    for (int i = 0; i < 16; i++) write(4'(i), 16'($urandom_range(1, 16'hFFFF)), tag);
  endtask

  int done_cnt;
  int guard;

  initial begin
    for (int i = 0; i < 16; i++) m_words[i] = '0;

    // 1: reset with a write pending
    rst = 1'b1; wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 16'hFFFF;
    step("rst0");
    step("rst1");
    rst = 1'b0; wr_valid = 1'b0;
    check("rst.bus_zero", word_bus, 256'b0);
    check("rst.ready", {255'b0, wr_ready}, 256'd1);
    step("post_rst");

    // 2: writes to both ends of the bank
    write(4'd0,  16'h1234, "w0");
    check("w0.word0", {240'b0, word_bus[15:0]}, 256'h1234);
    write(4'd15, 16'hBEEF, "w15");
    check("w15.word15", {240'b0, word_bus[255:240]}, 256'hBEEF);
    check("w15.mask", {240'b0, valid_mask}, 256'h8001);

    // 3: last write to the same address wins
    write(4'd5, 16'hAAAA, "w5a");
    write(4'd5, 16'h5555, "w5b");
    check("w5.word5", {240'b0, word_bus[95:80]}, 256'h5555);

    // 4: fill, then sequenced clear
    fill_all("fill");
    clr_req = 1'b1;
    step("clr_start");
    clr_req = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      step("clr_run");
      if (clr_done) done_cnt++;
    end
    step("clr_after");
    if (clr_done) done_cnt++;
    check("clr.done_once", 256'(done_cnt), 256'd1);
    check("clr.bank_zero", word_bus, 256'b0);
    check("clr.mask_zero", {240'b0, valid_mask}, 256'b0);

    // 5: write held across a clear stalls, then commits on the first IDLE edge
    fill_all("fill2");
    clr_req = 1'b1;
    step("clr2_start");
    clr_req = 1'b0;
    wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 16'h00C3;
    guard = 0;
    while (!wr_ready && guard < 40) begin
      step("clr2_stall");
      guard++;
    end
    check("clr2.stall_len", 256'(guard), 256'd16);
    step("clr2_commit");
    wr_valid = 1'b0;
    check("clr2.word7", {240'b0, word_bus[127:112]}, 256'h00C3);
    check("clr2.mask", {240'b0, valid_mask}, 256'h0080);

    // simultaneous write and clear request: clear wins in the end
    wr_valid = 1'b1; wr_addr = 4'd9; wr_data = 16'h1357; clr_req = 1'b1;
    step("both");
    idle_inputs();
    for (int k = 0; k < 17; k++) step("both_clr");
    check("both.bank_zero", word_bus, 256'b0);

    // 6: reset mid-clear
    fill_all("fill3");
    clr_req = 1'b1;
    step("clr3_start");
    clr_req = 1'b0;
    for (int k = 0; k < 5; k++) step("clr3_run");
    rst = 1'b1;
    step("clr3_rst");
    rst = 1'b0;
    check("clr3.busy", {255'b0, clr_busy}, 256'b0);
    check("clr3.bank_zero", word_bus, 256'b0);
    for (int k = 0; k < 20; k++) step("clr3_quiet");

    // random write traffic
    for (int k = 0; k < 40; k++)
      write(4'($urandom_range(0, 15)), 16'($urandom), "rand");

    if (sb.size() != 0) check("sb.empty", 256'(sb.size()), 256'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
